// File: rtl/iomem_bus_if.sv
// iomem_bus_if: core-side request/response and shared peripheral-side slot bus
interface iomem_bus_if #(
  parameter int NUM_SLOTS = 8
);
  logic                   m_valid;
  logic                   m_ready;
  logic [3:0]             m_wstrb;
  logic [31:0]            m_addr;
  logic [31:0]            m_wdata;
  logic [31:0]            m_rdata;
  logic [NUM_SLOTS-1:0]   s_valid;
  logic [3:0]             s_wstrb;
  logic [31:0]            s_addr;
  logic [31:0]            s_wdata;
  logic [NUM_SLOTS-1:0]   s_ready;
  logic [32*NUM_SLOTS-1:0] s_rdata;
  modport slave (
    input  m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
    output m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );
  modport master (
    output m_valid, m_wstrb, m_addr, m_wdata, s_ready, s_rdata,
    input  m_ready, m_rdata, s_valid, s_wstrb, s_addr, s_wdata
  );
endinterface

// File: rtl/iomem_bus_ctrl.sv
// iomem_bus_ctrl: decodes the peripheral slot, sequences the request and aborts stalled or unmapped accesses
module iomem_bus_ctrl #(
  parameter int          NUM_SLOTS = 8,
  parameter logic [7:0]  BASE_SLOT = 8'h03,
  parameter int unsigned TIMEOUT   = 1023,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  iomem_bus_if.slave  bus,
  output logic        bus_err,
  output logic [15:0] err_count,
  output logic        busy
);
  localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t               state, state_n;
  logic [SW-1:0]        sel, sel_n;
  logic [31:0]          cnt, cnt_n, rdata_n, addr_n, wdata_n;
  logic [3:0]           wstrb_n;
  logic [NUM_SLOTS-1:0] valid_n;
  logic                 err_n;
  logic [15:0]          ecnt_n;
  logic [7:0]           slot;
  logic [15:0]          ecnt_inc;
  assign slot     = bus.m_addr[31:24] - BASE_SLOT;
  assign ecnt_inc = err_count + 16'(err_count != 16'hFFFF);
  // next state and next values of every registered output
  always_comb begin
    state_n = state;
    sel_n   = sel;
    cnt_n   = cnt;
    rdata_n = bus.m_rdata;
    addr_n  = bus.s_addr;
    wdata_n = bus.s_wdata;
    wstrb_n = bus.s_wstrb;
    valid_n = bus.s_valid;
    err_n   = 1'b0;
    ecnt_n  = err_count;
    case (state)
      IDLE: if (bus.m_valid && !bus.m_ready) begin
        if (slot < 8'(NUM_SLOTS)) begin
          sel_n   = slot[SW-1:0];
          valid_n = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot[SW-1:0];
          addr_n  = bus.m_addr;
          wdata_n = bus.m_wdata;
          wstrb_n = bus.m_wstrb;
          cnt_n   = '0;
          state_n = ACCESS;
        end else begin
          rdata_n = ERR_DATA;
          err_n   = 1'b1;
          ecnt_n  = ecnt_inc;
          state_n = RESP;
        end
      end
      ACCESS: begin
        cnt_n = cnt + 32'd1;
        if (bus.s_ready[sel]) begin
          rdata_n = bus.s_rdata[32*sel +: 32];
          valid_n = '0;
          state_n = RESP;
        end else if (TIMEOUT != 0 && cnt == TIMEOUT - 1) begin
          rdata_n = ERR_DATA;
          valid_n = '0;
          err_n   = 1'b1;
          ecnt_n  = ecnt_inc;
          state_n = RESP;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // state and output registers; m_ready fires in the cycle after RESP
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= '0;
      cnt         <= '0;
      bus.m_ready <= 1'b0;
      bus.m_rdata <= '0;
      bus.s_valid <= '0;
      bus.s_wstrb <= '0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus_err     <= 1'b0;
      err_count   <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      sel         <= sel_n;
      cnt         <= cnt_n;
      bus.m_ready <= state == RESP;
      bus.m_rdata <= rdata_n;
      bus.s_valid <= valid_n;
      bus.s_wstrb <= wstrb_n;
      bus.s_addr  <= addr_n;
      bus.s_wdata <= wdata_n;
      bus_err     <= err_n;
      err_count   <= ecnt_n;
      busy        <= state_n != IDLE;
    end
  end
endmodule
